// File: rtl/sh7034_pkg.sv
// Shared SH7034 on-chip bus types and IBUS lane/data helpers.
package sh7034_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        WORD = 2'd1,
        LONG = 2'd2
    } IBUS_SZ_t;

    typedef enum logic [2:0] {
        II_IDLE      = 3'd0,
        II_ISSUE     = 3'd1,
        II_DATA_WAIT = 3'd2,
        II_DONE      = 3'd3,
        II_ERRRSP    = 3'd4
    } IBUS_INIT_STATE_t;

    // Big-endian lanes: BA[3] is byte offset 0 (bits 31:24).
    function automatic logic [3:0] ibus_lanes(
        input IBUS_SZ_t   sz,
        input logic [1:0] a
    );
        logic [3:0] ba;
        case (sz)
            BYTE:    ba = 4'b1000 >> a;
            WORD:    ba = a[1] ? 4'b0011 : 4'b1100;
            LONG:    ba = 4'b1111;
            default: ba = 4'b0000;
        endcase
        return ba;
    endfunction

    function automatic logic [31:0] ibus_wdata(
        input IBUS_SZ_t    sz,
        input logic [31:0] d
    );
        logic [31:0] w;
        case (sz)
            BYTE:    w = {4{d[7:0]}};
            WORD:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sh7034_ibus_rdalign.sv
// IBUS read lane extraction with zero/sign extension; shared with the DMAC.
module sh7034_ibus_rdalign (
    input  logic [3:0]  ba,
    input  logic [1:0]  a,
    input  logic        sext,
    input  logic [31:0] di,
    output logic [31:0] d
);

    logic [7:0]  b;
    logic [15:0] w;

    always_comb begin
        b = 8'h00;
        case (a)
            2'd0:    b = di[31:24];
            2'd1:    b = di[23:16];
            2'd2:    b = di[15:8];
            default: b = di[7:0];
        endcase
        w = a[1] ? di[15:0] : di[31:16];
        if (ba == 4'b1111) begin
            d = di;
        end else if (ba == 4'b1100 || ba == 4'b0011) begin
            d = {{16{sext & w[15]}}, w};
        end else begin
            d = {{24{sext & b[7]}}, b};
        end
    end

endmodule

// File: rtl/sh7034_ibus_initiator.sv
// Single-outstanding IBUS master: command/response to byte/word/long cycles.
module sh7034_ibus_initiator
    import sh7034_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WE,
    input  logic [1:0]  CMD_SZ,
    input  logic        CMD_SEXT,
    input  logic [27:0] CMD_A,
    input  logic [31:0] CMD_D,
    output logic        RSP_VALID,
    output logic [31:0] RSP_D,
    output logic        RSP_ERR,
    output logic [27:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    IBUS_INIT_STATE_t state_q, state_d;
    logic [27:0] a_q, a_d;
    logic [31:0] do_q, do_d;
    logic [3:0]  ba_q, ba_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic        sext_q, sext_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_d_q, rsp_d_d;
    logic        rsp_err_q, rsp_err_d;

    IBUS_SZ_t    cmd_sz;
    logic        cmd_bad;
    logic        fin;
    logic        fin_err;
    logic [31:0] fin_d;
    logic [31:0] rd_data;

    sh7034_ibus_rdalign u_rdalign (
        .ba   (ba_q),
        .a    (a_q[1:0]),
        .sext (sext_q),
        .di   (IBUS_DI),
        .d    (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        do_d        = do_q;
        ba_d        = ba_q;
        we_d        = we_q;
        req_d       = req_q;
        sext_d      = sext_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_d_d     = rsp_d_q;
        rsp_err_d   = rsp_err_q;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_d       = '0;
        cmd_sz      = IBUS_SZ_t'(CMD_SZ);
        cmd_bad     = (CMD_SZ == 2'd3)
                   || (CMD_SZ == 2'd1 && CMD_A[0])
                   || (CMD_SZ == 2'd2 && CMD_A[1:0] != 2'd0);

        unique case (state_q)
            II_IDLE: begin
                cnt_d = '0;
                if (CE_R && CMD_VALID) begin
                    if (cmd_bad) begin
                        state_d     = II_ERRRSP;
                        rsp_valid_d = 1'b1;
                        rsp_d_d     = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = II_ISSUE;
                        req_d   = 1'b1;
                        we_d    = CMD_WE;
                        ba_d    = ibus_lanes(cmd_sz, CMD_A[1:0]);
                        a_d     = CMD_A;
                        do_d    = CMD_WE ? ibus_wdata(cmd_sz, CMD_D) : '0;
                        sext_d  = CMD_SEXT;
                    end
                end
            end
            II_ISSUE: begin
                if (we_q && CE_R && !IBUS_BUSY) begin
                    fin     = 1'b1;
                    fin_err = !IBUS_ACT;
                end else if (!we_q && CE_F && !IBUS_BUSY) begin
                    state_d = II_DATA_WAIT;
                end else if (CE_R && IBUS_BUSY) begin
                    if (cnt_q + 10'd1 == TMO) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            // Peripheral latched its data on the accepting CE_F.
            II_DATA_WAIT: begin
                if (CE_R) begin
                    fin     = 1'b1;
                    fin_err = !IBUS_ACT;
                    fin_d   = IBUS_ACT ? rd_data : '0;
                end
            end
            II_DONE, II_ERRRSP: state_d = II_IDLE;
            default:            state_d = II_IDLE;
        endcase

        if (fin) begin
            state_d     = II_DONE;
            req_d       = 1'b0;
            we_d        = 1'b0;
            ba_d        = '0;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_d_d     = fin_d;
            rsp_err_d   = fin_err;
        end

        if (!RES_N) begin
            state_d     = II_IDLE;
            a_d         = '0;
            do_d        = '0;
            ba_d        = '0;
            we_d        = 1'b0;
            req_d       = 1'b0;
            sext_d      = 1'b0;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            rsp_d_d     = '0;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= II_IDLE;
            a_q         <= '0;
            do_q        <= '0;
            ba_q        <= '0;
            we_q        <= 1'b0;
            req_q       <= 1'b0;
            sext_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_d_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            do_q        <= do_d;
            ba_q        <= ba_d;
            we_q        <= we_d;
            req_q       <= req_d;
            sext_q      <= sext_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_d_q     <= rsp_d_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign CMD_READY = (state_q == II_IDLE) && RES_N;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_D     = rsp_d_q;
    assign RSP_ERR   = rsp_err_q;
    assign IBUS_A    = a_q;
    assign IBUS_DO   = do_q;
    assign IBUS_BA   = ba_q;
    assign IBUS_WE   = we_q;
    assign IBUS_REQ  = req_q;

endmodule

// File: tb/tb_sh7034_ibus_initiator.sv
// Directed plus random bench for sh7034_ibus_initiator against a byte-level model.
module tb_sh7034_ibus_initiator;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE_R = 1'b0;
    logic        CE_F = 1'b0;
    logic        RES_N = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WE = 1'b0;
    logic [1:0]  CMD_SZ = 2'd0;
    logic        CMD_SEXT = 1'b0;
    logic [27:0] CMD_A = '0;
    logic [31:0] CMD_D = '0;
    logic        RSP_VALID;
    logic [31:0] RSP_D;
    logic        RSP_ERR;
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [31:0] IBUS_DI = '0;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY = 1'b0;
    logic        IBUS_ACT = 1'b1;

    int total = 0;
    int bad = 0;
    int ph = 0;

    sh7034_ibus_initiator #(.TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE_R      (CE_R),
        .CE_F      (CE_F),
        .RES_N     (RES_N),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WE    (CMD_WE),
        .CMD_SZ    (CMD_SZ),
        .CMD_SEXT  (CMD_SEXT),
        .CMD_A     (CMD_A),
        .CMD_D     (CMD_D),
        .RSP_VALID (RSP_VALID),
        .RSP_D     (RSP_D),
        .RSP_ERR   (RSP_ERR),
        .IBUS_A    (IBUS_A),
        .IBUS_DO   (IBUS_DO),
        .IBUS_DI   (IBUS_DI),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_BUSY (IBUS_BUSY),
        .IBUS_ACT  (IBUS_ACT)
    );

    initial forever #5 CLK = ~CLK;

    // Phase enables change 2 time units after each rising edge.
    initial forever begin
        @(posedge CLK);
        #2;
        ph   = (ph + 1) % 4;
        CE_R = (ph == 0);
        CE_F = (ph == 2);
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_bad(input logic [1:0] sz, input logic [27:0] a);
        if (sz == 2'd3) return 1'b1;
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_ba(input logic [1:0] sz,
                                        input logic [27:0] a);
        logic [3:0] ba = '0;
        int off = int'(a[1:0]);
        for (int j = 0; j < nbytes(sz); j++) ba[3 - (off + j)] = 1'b1;
        return ba;
    endfunction

    function automatic logic [31:0] m_do(input logic [1:0] sz,
                                         input logic [31:0] d);
        logic [31:0] v = '0;
        logic [31:0] b;
        int n = nbytes(sz);
        for (int k = 0; k < 4; k++) begin
            b = (d >> (8 * (n - 1 - (k % n)))) & 32'hFF;
            v = v | (b << (8 * (3 - k)));
        end
        return v;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] sz,
                                         input logic [27:0] a,
                                         input bit sext,
                                         input logic [31:0] di);
        logic [31:0] v = '0;
        logic [31:0] b;
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        for (int j = 0; j < n; j++) begin
            b = (di >> (8 * (3 - (off + j)))) & 32'hFF;
            v = v | (b << (8 * (n - 1 - j)));
        end
        if (sext && n < 4 && v[8 * n - 1])
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic wait_accept(output bit ok);
        int g = 0;
        while (!(CE_R && CMD_READY) && g < 100) begin
            step();
            g++;
        end
        ok = (g < 100);
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input bit we,
                          input logic [1:0] sz, input bit sext,
                          input logic [27:0] a, input logic [31:0] d,
                          input logic [31:0] di, input bit act,
                          input int busy_n);
        bit ok;
        bit unstable = 1'b0;
        bit was_r;
        bit tmo = (busy_n >= TMO);
        int elapsed = 0;
        int guard = 0;
        logic        e_err;
        logic [31:0] e_d;
        logic [3:0]  e_ba = m_ba(sz, a);
        logic [31:0] e_do = m_do(sz, d);
        step();
        CMD_WE = we; CMD_SZ = sz; CMD_SEXT = sext;
        CMD_A = a; CMD_D = d; CMD_VALID = 1'b1;
        IBUS_DI = di; IBUS_ACT = act; IBUS_BUSY = (busy_n > 0);
        wait_accept(ok);
        chk({tag, ".accept"}, ok, 1'b1);
        if (m_bad(sz, a)) begin
            chk({tag, ".noreq"}, IBUS_REQ, 1'b0);
            chk({tag, ".evalid"}, RSP_VALID, 1'b1);
            chk({tag, ".eerr"}, RSP_ERR, 1'b1);
            chk({tag, ".ed"}, RSP_D, 32'h0);
            step();
            chk({tag, ".epulse"}, RSP_VALID, 1'b0);
            IBUS_BUSY = 1'b0;
            return;
        end
        chk({tag, ".req"}, IBUS_REQ, 1'b1);
        chk({tag, ".ba"}, IBUS_BA, e_ba);
        chk({tag, ".we"}, IBUS_WE, we);
        chk({tag, ".a"}, IBUS_A, a);
        if (we) chk({tag, ".do"}, IBUS_DO, e_do);
        while (RSP_VALID !== 1'b1 && guard < 400) begin
            if (IBUS_REQ !== 1'b1 || IBUS_A !== a || IBUS_BA !== e_ba ||
                IBUS_WE !== we || (we && IBUS_DO !== e_do))
                unstable = 1'b1;
            was_r = CE_R;
            step();
            guard++;
            if (was_r) elapsed++;
            IBUS_BUSY = (elapsed < busy_n);
        end
        IBUS_BUSY = 1'b0;
        e_err = tmo ? 1'b1 : !act;
        e_d = (e_err || we) ? 32'h0 : m_rd(sz, a, sext, di);
        chk({tag, ".rsp"}, RSP_VALID, 1'b1);
        chk({tag, ".stable"}, unstable, 1'b0);
        chk({tag, ".ticks"}, elapsed, tmo ? TMO : busy_n + 1);
        chk({tag, ".err"}, RSP_ERR, e_err);
        chk({tag, ".d"}, RSP_D, e_d);
        chk({tag, ".reqdrop"}, IBUS_REQ, 1'b0);
        chk({tag, ".badrop"}, IBUS_BA, 4'h0);
        step();
        chk({tag, ".pulse"}, RSP_VALID, 1'b0);
        chk({tag, ".hold"}, RSP_D, e_d);
    endtask

    initial begin
        bit ok;
        bit seen;
        bit we, sext, act;
        logic [1:0]  sz;
        logic [27:0] a;
        int r, bn;

        repeat (3) step();
        chk("rst.req", IBUS_REQ, 1'b0);
        chk("rst.a", IBUS_A, 28'h0);
        chk("rst.do", IBUS_DO, 32'h0);
        chk("rst.ba", IBUS_BA, 4'h0);
        chk("rst.we", IBUS_WE, 1'b0);
        chk("rst.rspv", RSP_VALID, 1'b0);
        chk("rst.rspd", RSP_D, 32'h0);
        chk("rst.rsperr", RSP_ERR, 1'b0);
        RST_N = 1'b1;
        step();
        chk("rst.ready", CMD_READY, 1'b1);

        do_cmd("wr_b", 1, 2'd0, 0, 28'h5FFFF04, 32'h0000001F, 0, 1, 0);
        do_cmd("rd_bs", 0, 2'd0, 1, 28'h5FFFF07, 32'h000000C3, 32'h000000C3, 1, 0);
        do_cmd("rd_bz", 0, 2'd0, 0, 28'h5FFFF07, 32'h0, 32'h000000C3, 1, 0);
        do_cmd("rd_w", 0, 2'd1, 0, 28'h5FFFF0A, 32'h0, 32'h12348001, 1, 0);
        do_cmd("wr_l", 1, 2'd2, 0, 28'h5FFFF08, 32'hDEADBEEF, 0, 1, 0);
        do_cmd("rd_mis", 0, 2'd2, 0, 28'h5FFFF06, 32'h0, 32'h11223344, 1, 0);
        do_cmd("sz3", 1, 2'd3, 0, 28'h5FFFF08, 32'h55, 0, 1, 0);
        do_cmd("wr_busy", 1, 2'd1, 0, 28'h5FFFF02, 32'hA5A51234, 0, 1, 3);
        do_cmd("wr_tmo", 1, 2'd2, 0, 28'h5FFFF0C, 32'h01020304, 0, 1, 1000);
        do_cmd("rd_tmo", 0, 2'd1, 1, 28'h5FFFF0E, 32'h0, 32'hFFFF8000, 1, 1000);
        do_cmd("rd_noact", 0, 2'd2, 0, 28'h5FFFF00, 32'h0, 32'hCAFEF00D, 0, 0);

        step();
        CMD_WE = 1; CMD_SZ = 2'd2; CMD_A = 28'h5FFFF10;
        CMD_D = 32'h01234567; CMD_VALID = 1; IBUS_BUSY = 1; IBUS_ACT = 1;
        wait_accept(ok);
        chk("arst.accept", ok, 1'b1);
        step();
        chk("arst.reqon", IBUS_REQ, 1'b1);
        #1 RST_N = 1'b0;
        #1;
        chk("arst.req", IBUS_REQ, 1'b0);
        chk("arst.a", IBUS_A, 28'h0);
        chk("arst.do", IBUS_DO, 32'h0);
        chk("arst.ba", IBUS_BA, 4'h0);
        chk("arst.we", IBUS_WE, 1'b0);
        step();
        RST_N = 1'b1;
        IBUS_BUSY = 0;
        seen = 0;
        repeat (40) begin
            step();
            if (RSP_VALID !== 1'b0) seen = 1;
        end
        chk("arst.norsp", seen, 1'b0);
        do_cmd("post_arst", 0, 2'd1, 1, 28'h5FFFF12, 32'h0, 32'h00007FFE, 1, 1);

        step();
        CMD_WE = 0; CMD_SZ = 2'd0; CMD_A = 28'h5FFFF01;
        CMD_VALID = 1; IBUS_BUSY = 1;
        wait_accept(ok);
        chk("sres.accept", ok, 1'b1);
        chk("sres.reqon", IBUS_REQ, 1'b1);
        RES_N = 1'b0;
        #1;
        chk("sres.ready", CMD_READY, 1'b0);
        step();
        chk("sres.req", IBUS_REQ, 1'b0);
        chk("sres.ba", IBUS_BA, 4'h0);
        RES_N = 1'b1;
        IBUS_BUSY = 0;
        seen = 0;
        repeat (40) begin
            step();
            if (RSP_VALID !== 1'b0) seen = 1;
        end
        chk("sres.norsp", seen, 1'b0);
        do_cmd("post_sres", 1, 2'd0, 0, 28'h5FFFF03, 32'h000000E7, 0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 15);
            sz   = (r < 14) ? 2'(r % 3) : 2'd3;
            a    = 28'($urandom);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~28'(nbytes(sz) - 1);
            we   = 1'($urandom_range(0, 1));
            sext = 1'($urandom_range(0, 1));
            act  = ($urandom_range(0, 7) != 0);
            r    = $urandom_range(0, 9);
            bn   = (r == 9) ? 50 : r % 4;
            do_cmd($sformatf("rnd%0d", i), we, sz, sext, a,
                   $urandom, $urandom, act, bn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sh7034_ibus_initiator.md
Name: sh7034_ibus_initiator

Overview:
- Single-outstanding IBUS initiator (master) for the SH7034 on-chip peripheral bus.
- Turns a simple command/response interface into byte, word or long IBUS cycles, driven by the same CE_R/CE_F phase enables the peripherals use.
- Generates big-endian byte lanes and replicates write data.
- Extracts and extends read data, and reports bus errors: no peripheral claimed the cycle, misalignment, or BUSY timeout.
- Sits between the CPU/DMAC-side access logic and peripherals such as the ITU.

Parameters:
- TIMEOUT, 255, number of CE_R ticks with IBUS_BUSY high before the cycle is aborted with an error (range 1..1023).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  rising-phase clock enable
- CE_F  in  1  falling-phase clock enable
- RES_N  in  1  synchronous soft reset, active-low (acts on any CLK edge)
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted when VALID&READY on a CE_R tick
- CMD_WE  in  1  1=write, 0=read
- CMD_SZ  in  2  0=byte, 1=word, 2=long, 3=reserved (error)
- CMD_SEXT  in  1  sign-extend read data (byte/word)
- CMD_A  in  28  byte address
- CMD_D  in  32  write data, right-justified
- RSP_VALID  out  1  one-CLK pulse, response valid
- RSP_D  out  32  read data (0 for writes/errors)
- RSP_ERR  out  1  error flag, qualified by RSP_VALID
- IBUS_A  out  28  address
- IBUS_DO  out  32  write data to peripherals
- IBUS_DI  in  32  read data from peripherals
- IBUS_BA  out  4  byte lanes; BA[3]=bits 31:24=byte offset 0
- IBUS_WE  out  1  write strobe
- IBUS_REQ  out  1  cycle request
- IBUS_BUSY  in  1  peripheral stall
- IBUS_ACT  in  1  some peripheral decodes IBUS_A

Behaviour:
- Reset (RST_N low or RES_N low): state IDLE; IBUS_A=0, IBUS_DO=0, IBUS_BA=0, IBUS_WE=0, IBUS_REQ=0; RSP_VALID=0, RSP_D=0, RSP_ERR=0; timeout counter=0.
- RES_N or RST_N mid-cycle: REQ drops immediately and no response is issued.
- CMD_READY = (state==IDLE) && RES_N.
- States:
  - IDLE -> ISSUE on an accepted command; IDLE -> ERRRSP on a misaligned or reserved-size command.
  - ISSUE -> DATA_WAIT for reads; ISSUE -> DONE for writes.
  - DATA_WAIT -> DONE.
  - DONE -> IDLE.
  - ERRRSP -> IDLE.
- Alignment: word needs A[0]=0; long needs A[1:0]=0; SZ=3 is always an error. Misaligned commands never assert IBUS_REQ and respond RSP_ERR=1 one CLK after acceptance.
- Lanes:
  - byte: BA = 4'b1000 >> A[1:0]
  - word: BA = A[1] ? 4'b0011 : 4'b1100
  - long: BA = 4'b1111
- Write data: byte = {4{D[7:0]}}; word = {2{D[15:0]}}; long = D.
- IBUS_A = CMD_A unmodified.
- ISSUE: IBUS_REQ, IBUS_A, IBUS_BA, IBUS_WE and IBUS_DO are registered at the accepting CE_R tick and held stable until the cycle ends.
- Write completion: at the first subsequent CE_R tick with IBUS_BUSY=0, drop REQ/WE/BA and go to DONE.
- Read completion, two steps:
  - At the first CE_F tick with IBUS_BUSY=0, mark the cycle accepted (the peripheral registers its data on that CE_F).
  - At the next CE_R tick, capture IBUS_DI, drop REQ, and go to DONE.
- Read extraction: select the lane(s) addressed by A, right-justify, then zero-extend, or sign-extend if SEXT.
- IBUS_ACT is sampled at completion; if it is 0, RSP_ERR=1 and RSP_D=0.
- BUSY timeout: the counter increments on each CE_R tick with REQ=1 && BUSY=1 and clears on acceptance. Reaching TIMEOUT aborts the cycle: REQ drops and the response is RSP_ERR=1, RSP_D=0.
- DONE: RSP_VALID pulses for exactly one CLK, with RSP_D/RSP_ERR valid on that CLK. RSP_D/RSP_ERR hold until the next response.
- Minimum command spacing: a new command is accepted at the CE_R tick after DONE. Back-to-back writes therefore take 2 CE_R periods each.

Decomposition:
- Shared package SH7034_PKG gains:
  - IBUS_SZ_t enum (BYTE, WORD, LONG)
  - IBUS_INIT_STATE_t enum
  - a function computing BA from size and A[1:0]
  - a function replicating write data
- Sub-module sh7034_ibus_rdalign: combinational lane extraction plus sign/zero extension from BA, A[1:0], SEXT and DI. It is reused by the DMAC.

Test Plan:
- Byte write 0x1F to 0x5FFFF04 (ACT=1, BUSY=0) -> exactly one cycle with BA=1000, DO=0x1F1F1F1F, WE=1; then RSP_ERR=0.
- Byte read 0x5FFFF07 with DI=0x000000C3, SEXT=1 -> BA=0001, RSP_D=0xFFFFFFC3. Same read with SEXT=0 -> RSP_D=0x000000C3.
- Word read 0x5FFFF0A with DI=0x12348001, SEXT=0 -> BA=0011, RSP_D=0x00008001. Long write of 0xDEADBEEF to 0x5FFFF08 -> BA=1111, DO=0xDEADBEEF.
- Long read from 0x5FFFF06 (misaligned), and any command with SZ=3 -> IBUS_REQ never asserted; RSP_VALID with RSP_ERR=1 and RSP_D=0.
- BUSY held high for 3 CE_R ticks on a write -> REQ and all bus signals stable for 4 CE_R ticks, then success. BUSY held high forever with TIMEOUT=8 -> REQ drops after 8 ticks, RSP_ERR=1.
- Read with ACT=0 -> RSP_ERR=1. RST_N pulsed while REQ=1 -> all outputs 0 and no RSP_VALID. The next command completes normally.
